// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: serialises instruction-fetch and data read/write requests from the CPU
// datapath into one outstanding memory transaction at a time, in front of the memory I/O
// bus stage.
//
// Ports:
//   clk, reset_n              rising-edge clock, asynchronous active-low reset
//   fetch_req, fetch_addr     instruction fetch request (level) and address
//   data_rd_req, data_wr_req  data read / write requests (level)
//   data_addr, data_wdata     data address and store data
//   input_ready, mem_rdata    memory completion indication and returned word
//   sig_fetch/read/write      active transaction type (state decode)
//   address_fetch_out         latched fetch address
//   address_data_out          latched data address
//   data_write                latched store data
//   instr, instr_valid        last fetched instruction, one-cycle update pulse
//   rdata, data_done          last loaded word, one-cycle data completion pulse
//   busy                      transaction in progress
//   timeout_err               one-cycle pulse: transaction abandoned on timeout
module mem_access_ctrl #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_req,
  input  logic [WORD_SIZE-1:0] fetch_addr,
  input  logic                 data_rd_req,
  input  logic                 data_wr_req,
  input  logic [WORD_SIZE-1:0] data_addr,
  input  logic [WORD_SIZE-1:0] data_wdata,
  input  logic                 input_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 sig_fetch,
  output logic                 sig_read,
  output logic                 sig_write,
  output logic [WORD_SIZE-1:0] address_fetch_out,
  output logic [WORD_SIZE-1:0] address_data_out,
  output logic [WORD_SIZE-1:0] data_write,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 data_done,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StRead, StWrite} state_e;

  // Last wait-count value before the transaction is abandoned.
  localparam logic [7:0] WaitMax = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] wait_cnt_q;

  // Moore decodes of the state register.
  assign sig_fetch = (state_q == StFetch);
  assign sig_read  = (state_q == StRead);
  assign sig_write = (state_q == StWrite);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= StIdle;
      wait_cnt_q        <= 8'd0;
      address_fetch_out <= '0;
      address_data_out  <= '0;
      data_write        <= '0;
      instr             <= '0;
      instr_valid       <= 1'b0;
      rdata             <= '0;
      data_done         <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      data_done   <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Writes beat reads beat fetches; input_ready is ignored here.
          if (data_wr_req) begin
            address_data_out <= data_addr;
            data_write       <= data_wdata;
            wait_cnt_q       <= 8'd0;
            state_q          <= StWrite;
          end else if (data_rd_req) begin
            address_data_out <= data_addr;
            wait_cnt_q       <= 8'd0;
            state_q          <= StRead;
          end else if (fetch_req) begin
            address_fetch_out <= fetch_addr;
            wait_cnt_q        <= 8'd0;
            state_q           <= StFetch;
          end
        end
        StFetch, StRead, StWrite: begin
          // Completion wins over a coincident timeout.
          if (input_ready) begin
            state_q <= StIdle;
            if (state_q == StFetch) begin
              instr       <= mem_rdata;
              instr_valid <= 1'b1;
            end else if (state_q == StRead) begin
              rdata     <= mem_rdata;
              data_done <= 1'b1;
            end else begin
              data_done <= 1'b1;
            end
          end else if (wait_cnt_q == WaitMax) begin
            state_q     <= StIdle;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req, data_rd_req, data_wr_req, input_ready;
  logic [15:0] fetch_addr, data_addr, data_wdata, mem_rdata;
  logic        sig_fetch, sig_read, sig_write;
  logic [15:0] address_fetch_out, address_data_out, data_write, instr, rdata;
  logic        instr_valid, data_done, busy, timeout_err;

  int vectors = 0;
  int errors  = 0;

  mem_access_ctrl #(.WORD_SIZE(16), .TIMEOUT(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .data_rd_req      (data_rd_req),
    .data_wr_req      (data_wr_req),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .input_ready      (input_ready),
    .mem_rdata        (mem_rdata),
    .sig_fetch        (sig_fetch),
    .sig_read         (sig_read),
    .sig_write        (sig_write),
    .address_fetch_out(address_fetch_out),
    .address_data_out (address_data_out),
    .data_write       (data_write),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .rdata            (rdata),
    .data_done        (data_done),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  // Step to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    fetch_req = 0; data_rd_req = 0; data_wr_req = 0; input_ready = 0;
    fetch_addr = 0; data_addr = 0; data_wdata = 0; mem_rdata = 0;
    tick();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_sig", {13'd0, sig_fetch, sig_read, sig_write}, 16'd0);
    check("rst_instr", instr, 16'h0000);
    check("rst_rdata", rdata, 16'h0000);
    reset_n = 1'b1;
    tick();

    // 1: asynchronous reset mid-fetch
    fetch_req = 1; fetch_addr = 16'h0077;
    tick();
    check("t1_sig_fetch", 16'(sig_fetch), 16'd1);
    check("t1_faddr", address_fetch_out, 16'h0077);
    #3 reset_n = 1'b0;
    #1;
    check("t1_async_sig", 16'(sig_fetch), 16'd0);
    check("t1_async_faddr", address_fetch_out, 16'h0000);
    check("t1_async_busy", 16'(busy), 16'd0);
    fetch_req = 0;
    tick();
    reset_n = 1'b1;
    tick();
    check("t1_post_busy", 16'(busy), 16'd0);
    check("t1_post_valid", 16'(instr_valid), 16'd0);

    // 2: fetch with input_ready on the third waiting cycle
    fetch_req = 1; fetch_addr = 16'h0040; mem_rdata = 16'hA5C3;
    tick();
    check("t2_c1_sig", 16'(sig_fetch), 16'd1);
    check("t2_c1_addr", address_fetch_out, 16'h0040);
    tick();
    check("t2_c2_sig", 16'(sig_fetch), 16'd1);
    tick();
    check("t2_c3_sig", 16'(sig_fetch), 16'd1);
    check("t2_c3_valid", 16'(instr_valid), 16'd0);
    input_ready = 1;
    tick();
    check("t2_done_sig", 16'(sig_fetch), 16'd0);
    check("t2_done_busy", 16'(busy), 16'd0);
    check("t2_instr", instr, 16'hA5C3);
    check("t2_valid", 16'(instr_valid), 16'd1);
    fetch_req = 0; input_ready = 0;
    tick();
    check("t2_valid_pulse", 16'(instr_valid), 16'd0);
    check("t2_idle_busy", 16'(busy), 16'd0);

    // input_ready while idle is ignored
    input_ready = 1;
    tick();
    check("idle_rdy_busy", 16'(busy), 16'd0);
    check("idle_rdy_done", 16'(data_done), 16'd0);
    input_ready = 0;

    // 3: priority write > read > fetch
    data_wr_req = 1; data_rd_req = 1; fetch_req = 1;
    data_addr = 16'h0010; data_wdata = 16'h1234; fetch_addr = 16'h0080;
    mem_rdata = 16'hBEEF; input_ready = 1;
    tick();
    check("t3_sig", {13'd0, sig_fetch, sig_read, sig_write}, 16'b001);
    check("t3_wdata", data_write, 16'h1234);
    check("t3_daddr", address_data_out, 16'h0010);
    tick();
    check("t3_wr_done", 16'(data_done), 16'd1);
    check("t3_wr_rdata", rdata, 16'h0000);
    check("t3_wr_busy", 16'(busy), 16'd0);
    data_wr_req = 0;
    tick();
    check("t3_rd_sig", {13'd0, sig_fetch, sig_read, sig_write}, 16'b010);
    check("t3_rd_done0", 16'(data_done), 16'd0);
    tick();
    check("t3_rd_done", 16'(data_done), 16'd1);
    check("t3_rd_rdata", rdata, 16'hBEEF);
    data_rd_req = 0;
    tick();
    check("t3_f_sig", {13'd0, sig_fetch, sig_read, sig_write}, 16'b100);
    check("t3_f_addr", address_fetch_out, 16'h0080);
    check("t3_f_whold", data_write, 16'h1234);
    tick();
    check("t3_f_valid", 16'(instr_valid), 16'd1);
    check("t3_f_instr", instr, 16'hBEEF);
    fetch_req = 0; input_ready = 0;
    tick();

    // 4: back-to-back reads with input_ready held high
    data_rd_req = 1; data_addr = 16'h0020; input_ready = 1; mem_rdata = 16'h0001;
    tick();
    check("t4_busy1", 16'(busy), 16'd1);
    tick();
    check("t4_busy0", 16'(busy), 16'd0);
    check("t4_rdata1", rdata, 16'h0001);
    check("t4_done1", 16'(data_done), 16'd1);
    mem_rdata = 16'h0002;
    tick();
    check("t4_busy1b", 16'(busy), 16'd1);
    tick();
    check("t4_busy0b", 16'(busy), 16'd0);
    check("t4_rdata2", rdata, 16'h0002);
    data_rd_req = 0; input_ready = 0;
    tick();

    // 5: timeout after 4 waiting cycles
    data_rd_req = 1; data_addr = 16'h0030; mem_rdata = 16'hDEAD;
    tick();
    data_rd_req = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_sig_c%0d", i + 1), 16'(sig_read), 16'd1);
      check($sformatf("t5_to_c%0d", i + 1), 16'(timeout_err), 16'd0);
      tick();
    end
    check("t5_to", 16'(timeout_err), 16'd1);
    check("t5_sig_off", 16'(sig_read), 16'd0);
    check("t5_done", 16'(data_done), 16'd0);
    check("t5_rdata", rdata, 16'h0002);
    fetch_req = 1; fetch_addr = 16'h0090;
    tick();
    check("t5_to_pulse", 16'(timeout_err), 16'd0);
    check("t5_next_sig", 16'(sig_fetch), 16'd1);
    check("t5_next_addr", address_fetch_out, 16'h0090);
    input_ready = 1; mem_rdata = 16'h5555;
    tick();
    check("t5_next_instr", instr, 16'h5555);
    fetch_req = 0; input_ready = 0;
    tick();

    // 6: input_ready on the last waiting cycle completes normally
    data_wr_req = 1; data_addr = 16'h00A0; data_wdata = 16'h4321;
    tick();
    data_wr_req = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_sig_c%0d", i + 1), 16'(sig_write), 16'd1);
      tick();
    end
    check("t6_sig_c4", 16'(sig_write), 16'd1);
    input_ready = 1;
    tick();
    check("t6_done", 16'(data_done), 16'd1);
    check("t6_no_to", 16'(timeout_err), 16'd0);
    check("t6_rdata", rdata, 16'h0002);
    input_ready = 0;
    tick();
    check("t6_done_pulse", 16'(data_done), 16'd0);
    check("t6_no_to2", 16'(timeout_err), 16'd0);
    check("t6_busy", 16'(busy), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-access sequencer that sits directly upstream of the memory I/O bus stage.
- Accepts instruction-fetch and data read/write requests from the CPU datapath and serialises them into one outstanding memory transaction at a time.
- Drives sig_fetch/sig_read/sig_write, the addresses and the write data to the bus stage.
- Waits for the memory's input_ready, then latches the returned word and pulses a completion strobe back to the datapath.

Parameters:
WORD_SIZE, 16, data/address width (matches `WORD_SIZE).
TIMEOUT, 255, maximum wait cycles for input_ready before the transaction is abandoned; legal range 1..255, width 8 bits.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
fetch_req  input  1  level request for an instruction fetch.
fetch_addr  input  WORD_SIZE  instruction address.
data_rd_req  input  1  level request for a data read.
data_wr_req  input  1  level request for a data write.
data_addr  input  WORD_SIZE  data address.
data_wdata  input  WORD_SIZE  store data.
input_ready  input  1  memory completion indication.
mem_rdata  input  WORD_SIZE  word returned by the bus stage (its data_out).
sig_fetch  output  1  fetch transaction active.
sig_read  output  1  data-read transaction active.
sig_write  output  1  data-write transaction active.
address_fetch_out  output  WORD_SIZE  latched fetch address.
address_data_out  output  WORD_SIZE  latched data address.
data_write  output  WORD_SIZE  latched store data.
instr  output  WORD_SIZE  last fetched instruction.
instr_valid  output  1  one-cycle pulse: instr updated.
rdata  output  WORD_SIZE  last loaded data word.
data_done  output  1  one-cycle pulse: data read or write completed.
busy  output  1  transaction in progress.
timeout_err  output  1  one-cycle pulse: transaction abandoned.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State=IDLE, wait counter=0.
  - All outputs 0, including instr, rdata and the latched addresses/data.
  - Reset asserted mid-transaction drops the transaction immediately; no done or error pulse is produced.
- States: IDLE, FETCH, READ, WRITE. State is registered; sig_* and busy are pure state decodes (Moore).
  - sig_fetch=1 only in FETCH, sig_read=1 only in READ, sig_write=1 only in WRITE.
  - busy=1 in any non-IDLE state.
  - At most one of sig_* is ever high.
- IDLE arbitration, evaluated each cycle: data_wr_req > data_rd_req > fetch_req.
  - On the accepting edge: latch data_addr/data_wdata (WRITE), data_addr (READ) or fetch_addr (FETCH) into the address_*/data_write registers.
  - Clear the wait counter and enter the corresponding state.
  - Registers not involved in the accepted transaction hold their values.
- Access states:
  - input_ready=1 at a rising edge completes the transaction; next state is IDLE.
  - FETCH: instr<=mem_rdata, instr_valid=1 for the following cycle.
  - READ: rdata<=mem_rdata, data_done=1 for the following cycle.
  - WRITE: data_done=1 for the following cycle; rdata is unchanged.
  - Otherwise the wait counter increments. If the counter equals TIMEOUT-1 and input_ready=0, go to IDLE, pulse timeout_err for one cycle, and leave instr/rdata unchanged.
  - input_ready on the same edge as the timeout condition counts as completion, not timeout.
- Timing:
  - Request seen at edge N → sig_* high from cycle N+1.
  - input_ready sampled at edge M → pulse and busy=0 during cycle M+1.
  - A new request may be accepted at edge M+1; there are no bubble cycles beyond the IDLE cycle.
- Minimum transaction latency (request to pulse): 2 cycles.
- input_ready while IDLE is ignored.
- Request inputs are not sampled during access states. The datapath deasserts a request in the cycle its done pulse is seen; a request still high in IDLE is treated as a new transaction.
- Address and data outputs stay stable for the whole transaction, regardless of input changes.

Test Plan:
1. Reset: reset_n=0 mid-FETCH → all outputs 0 asynchronously. After release, state IDLE and busy=0.
2. Fetch: fetch_req=1, fetch_addr=16'h0040, memory returns 16'hA5C3 with input_ready 3 cycles later →
   - sig_fetch high for exactly 3 cycles, address_fetch_out=16'h0040;
   - then instr=16'hA5C3 with a single-cycle instr_valid.
3. Priority: data_wr_req, data_rd_req and fetch_req all high in IDLE, data_addr=16'h0010, data_wdata=16'h1234 →
   - WRITE first: sig_write=1, data_write=16'h1234;
   - on completion data_done pulses, then READ is served, then FETCH.
4. Back-to-back reads with input_ready held at 1 → each read occupies 2 cycles, with busy toggling 1,0,1,0. rdata takes each returned word in order (16'h0001, 16'h0002).
5. Timeout with TIMEOUT=4 and no input_ready → sig_read high for 4 cycles, then timeout_err pulses once. rdata keeps its prior value and the next request is accepted.
6. Boundary: input_ready first asserted on the 4th waiting cycle (TIMEOUT=4) → normal completion (data_done=1) and no timeout_err.
